// File: rtl/debouncer_multicanal.sv
// N-channel button conditioner: 2-FF sync, bounce filter, press/release pulses, wrapping event counters.
// Latency: clean input edge -> btn_level/pulse after 2+DEBOUNCE_CYCLES clocks; counters update one clock after the pulse.
// No backpressure: pulses are single-cycle and unconditional; optional hold detector under `LONG_PRESS_EN`.
module debouncer_multicanal #(
    parameter int N_CH            = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 8,
    parameter int LONG_CYCLES     = 100000000
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [N_CH-1:0]         btn_in,
    input  logic [1:0]              edge_mode,
    input  logic                    clear_cnt,
    output logic [N_CH-1:0]         btn_level,
    output logic [N_CH-1:0]         press_pulse,
    output logic [N_CH-1:0]         release_pulse,
    output logic [N_CH*CNT_W-1:0]   event_cnt,
    output logic [N_CH-1:0]         long_press
);

    localparam int FW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [FW-1:0] F_LAST = FW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'd0,
        WAIT_HIGH   = 2'd1,
        STABLE_HIGH = 2'd2,
        WAIT_LOW    = 2'd3
    } db_state_t;

    logic [N_CH-1:0] sync_a;
    logic [N_CH-1:0] sync_b;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= btn_in;
            sync_b <= sync_a;
        end
    end

    // edge_mode: 00 press, 01 release, 10 both, 11 none
    logic count_press;
    logic count_release;
    assign count_press   = (edge_mode == 2'b00) || (edge_mode == 2'b10);
    assign count_release = (edge_mode == 2'b01) || (edge_mode == 2'b10);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        db_state_t        state;
        logic [FW-1:0]    fcnt;
        logic             lvl;
        logic             pp;
        logic             rp;
        logic [CNT_W-1:0] ecnt;

        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                state <= STABLE_LOW;
                fcnt  <= '0;
                lvl   <= 1'b0;
                pp    <= 1'b0;
                rp    <= 1'b0;
            end else begin
                pp <= 1'b0;
                rp <= 1'b0;
                case (state)
                    STABLE_LOW: begin
                        if (sync_b[i]) begin
                            state <= WAIT_HIGH;
                            fcnt  <= FW'(1);
                        end
                    end
                    WAIT_HIGH: begin
                        if (!sync_b[i]) begin
                            state <= STABLE_LOW;
                            fcnt  <= '0;
                        end else if (fcnt == F_LAST) begin
                            state <= STABLE_HIGH;
                            fcnt  <= '0;
                            lvl   <= 1'b1;
                            pp    <= 1'b1;
                        end else begin
                            fcnt <= fcnt + FW'(1);
                        end
                    end
                    STABLE_HIGH: begin
                        if (!sync_b[i]) begin
                            state <= WAIT_LOW;
                            fcnt  <= FW'(1);
                        end
                    end
                    WAIT_LOW: begin
                        if (sync_b[i]) begin
                            state <= STABLE_HIGH;
                            fcnt  <= '0;
                        end else if (fcnt == F_LAST) begin
                            state <= STABLE_LOW;
                            fcnt  <= '0;
                            lvl   <= 1'b0;
                            rp    <= 1'b1;
                        end else begin
                            fcnt <= fcnt + FW'(1);
                        end
                    end
                    default: begin
                        state <= STABLE_LOW;
                        fcnt  <= '0;
                    end
                endcase
            end
        end

        // Counts from the registered pulse, so a clear raised during the pulse cycle wins.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                ecnt <= '0;
            end else if (clear_cnt) begin
                ecnt <= '0;
            end else if ((pp && count_press) || (rp && count_release)) begin
                ecnt <= ecnt + CNT_W'(1);
            end
        end

        assign btn_level[i]                 = lvl;
        assign press_pulse[i]               = pp;
        assign release_pulse[i]             = rp;
        assign event_cnt[i*CNT_W +: CNT_W]  = ecnt;

`ifdef LONG_PRESS_EN
        localparam int HW = $clog2(LONG_CYCLES + 1);
        logic [HW-1:0] hold;
        logic          lp;

        // Saturating at LONG_CYCLES guarantees a single pulse per press.
        always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
                hold <= '0;
                lp   <= 1'b0;
            end else begin
                lp <= 1'b0;
                if (!lvl) begin
                    hold <= '0;
                end else if (hold != HW'(LONG_CYCLES)) begin
                    hold <= hold + HW'(1);
                    if (hold == HW'(LONG_CYCLES - 1))
                        lp <= 1'b1;
                end
            end
        end

        assign long_press[i] = lp;
`endif
    end

`ifndef LONG_PRESS_EN
    assign long_press = '0;
`endif

endmodule

// File: tb/tb_debouncer_multicanal.sv
// Directed bench for debouncer_multicanal with N_CH=2, DEBOUNCE_CYCLES=4, CNT_W=4, LONG_CYCLES=20.
module tb_debouncer_multicanal;

    localparam int N_CH = 2;
    localparam int DB   = 4;
    localparam int CW   = 4;
    localparam int LC   = 20;

`ifdef LONG_PRESS_EN
    localparam logic [31:0] EXP_LP = 32'h3;
`else
    localparam logic [31:0] EXP_LP = 32'h0;
`endif

    logic                 clock = 1'b0;
    logic                 reset;
    logic [N_CH-1:0]      btn_in;
    logic [1:0]           edge_mode;
    logic                 clear_cnt;
    logic [N_CH-1:0]      btn_level;
    logic [N_CH-1:0]      press_pulse;
    logic [N_CH-1:0]      release_pulse;
    logic [N_CH*CW-1:0]   event_cnt;
    logic [N_CH-1:0]      long_press;

    int vectors     = 0;
    int miscompares = 0;
    int seen;

    debouncer_multicanal #(
        .N_CH(N_CH), .DEBOUNCE_CYCLES(DB), .CNT_W(CW), .LONG_CYCLES(LC)
    ) dut (
        .clock(clock), .reset(reset), .btn_in(btn_in), .edge_mode(edge_mode),
        .clear_cnt(clear_cnt), .btn_level(btn_level), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .event_cnt(event_cnt), .long_press(long_press)
    );

    always #5 clock = ~clock;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_level"}, 32'(btn_level), 32'h0);
        check({tag, "_press"}, 32'(press_pulse), 32'h0);
        check({tag, "_release"}, 32'(release_pulse), 32'h0);
        check({tag, "_cnt"}, 32'(event_cnt), 32'h0);
        check({tag, "_long"}, 32'(long_press), 32'h0);
    endtask

    initial begin
        // 1: reset with toggling inputs, then idle
        reset = 1'b0; btn_in = '0; edge_mode = 2'b00; clear_cnt = 1'b0;
        for (int i = 0; i < 6; i++) begin
            btn_in = ~btn_in;
            step(1);
        end
        check_all_zero("reset");
        reset = 1'b1; btn_in = '0;
        step(8);
        check_all_zero("idle");

        // 2: chatter on ch0 for 30 cycles, then clean hold
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            btn_in[0] = (i % 2 == 0);
            step(1);
            if (press_pulse != '0) seen++;
        end
        check("chatter_no_press", 32'(seen), 32'h0);
        check("chatter_level", 32'(btn_level), 32'h0);
        btn_in[0] = 1'b1;
        step(5);
        check("lat5_level", 32'(btn_level), 32'h0);
        step(1);
        check("lat6_level", 32'(btn_level), 32'h1);
        check("lat6_press", 32'(press_pulse), 32'h1);
        step(1);
        check("press_one_cycle", 32'(press_pulse), 32'h0);
        check("press_counted", 32'(event_cnt), 32'h01);
        edge_mode = 2'b11;
        btn_in[0] = 1'b0;
        step(6);
        check("rel_pulse", 32'(release_pulse), 32'h1);
        check("rel_level", 32'(btn_level), 32'h0);
        step(2);
        check("mode11_nocount", 32'(event_cnt), 32'h01);
        clear_cnt = 1'b1;
        step(1);
        clear_cnt = 1'b0;
        check("clear_plain", 32'(event_cnt), 32'h0);

        // 3: 17 press/release pairs counting both edges -> 34 mod 16
        edge_mode = 2'b10;
        for (int p = 0; p < 17; p++) begin
            btn_in[0] = 1'b1;
            step(8);
            btn_in[0] = 1'b0;
            step(8);
            if (p == 6) check("both_after7", 32'(event_cnt), 32'h0E);
        end
        check("both_wrap", 32'(event_cnt), 32'h02);

        // 4: clear coincident with ch1 press pulse
        edge_mode = 2'b00;
        btn_in[1] = 1'b1;
        step(5);
        check("ch1_pre", 32'(press_pulse), 32'h0);
        step(1);
        check("ch1_press", 32'(press_pulse), 32'h2);
        clear_cnt = 1'b1;
        step(1);
        clear_cnt = 1'b0;
        check("clear_prio", 32'(event_cnt), 32'h0);
        step(2);
        check("clear_hold", 32'(event_cnt), 32'h0);
        btn_in[1] = 1'b0;
        step(8);
        check("ch1_released", 32'(btn_level), 32'h0);
        check("mode00_rel_nocount", 32'(event_cnt), 32'h0);

        // 5/6: simultaneous press on both channels, then hold for long press
        btn_in = 2'b11;
        step(6);
        check("dual_press", 32'(press_pulse), 32'h3);
        check("dual_level", 32'(btn_level), 32'h3);
        step(1);
        check("dual_cnt", 32'(event_cnt), 32'h11);
        seen = 0;
        for (int k = 0; k < 18; k++) begin
            step(1);
            if (long_press != '0) seen++;
        end
        check("long_early", 32'(seen), 32'h0);
        step(1);
        check("long_at20", 32'(long_press), EXP_LP);
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            step(1);
            if (long_press != '0) seen++;
        end
        check("long_once", 32'(seen), 32'h0);
        btn_in = 2'b00;
        step(8);
        check("dual_release", 32'(btn_level), 32'h0);
        check("dual_cnt_kept", 32'(event_cnt), 32'h11);

        // reset while ch0 sits in WAIT_HIGH
        btn_in[0] = 1'b1;
        step(4);
        reset = 1'b0;
        step(1);
        check_all_zero("midreset");
        reset = 1'b1;
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step(1);
            if (press_pulse != '0 || btn_level != '0) seen++;
        end
        check("midreset_no_early", 32'(seen), 32'h0);
        step(1);
        check("midreset_fresh_press", 32'(press_pulse), 32'h1);
        check("midreset_fresh_level", 32'(btn_level), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
